// File: rtl/accel_apb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : accel_apb_arbiter (with package accel_apb_pkg)
//  Purpose  : Shares one downstream APB segment between NMST upstream APB
//             masters. Round-robin arbitration per transfer, registered
//             request/response stages, watchdog-terminated hung transfers.
//  Ports    : i_clk, i_nrst       clock, asynchronous active-low reset
//             i_mst_apbi[NMST]    upstream master requests
//             o_mst_apbo[NMST]    upstream responses (only owner sees pready)
//             o_slv_apbi          registered downstream request
//             i_slv_apbo          downstream response
//             o_grant             one-hot current owner, zero when idle
//             o_timeout           one-cycle pulse when the watchdog fires
//  Revision : 1.0  initial release
// ============================================================================

package accel_apb_pkg;

    typedef struct packed {
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic        pselx;
        logic        penable;
        logic [2:0]  pprot;
    } apb_in_type;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_out_type;

    localparam apb_in_type  apb_in_none  = '0;
    localparam apb_out_type apb_out_none = '0;

endpackage

module accel_apb_arbiter
    import accel_apb_pkg::*;
#(
    parameter int NMST    = 2,
    parameter int TIMEOUT = 256
) (
    input  logic            i_clk,
    input  logic            i_nrst,
    input  apb_in_type      i_mst_apbi [NMST],
    output apb_out_type     o_mst_apbo [NMST],
    output apb_in_type      o_slv_apbi,
    input  apb_out_type     i_slv_apbo,
    output logic [NMST-1:0] o_grant,
    output logic            o_timeout
);

    localparam int IDXW = $clog2(NMST);
    // A zero TIMEOUT still needs a 1-bit counter to keep the logic legal.
    localparam int WDW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0]  WDOG_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
    localparam logic [IDXW-1:0] LAST_RST  = IDXW'(NMST - 1);
    localparam logic [NMST-1:0] GRANT_ONE = {{(NMST-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t          state_q,    state_d;
    logic [IDXW-1:0] last_q,     last_d;
    logic [WDW-1:0]  wdog_q,     wdog_d;
    logic [NMST-1:0] grant_q,    grant_d;
    apb_in_type      slv_q,      slv_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q,  rsp_err_d;

    logic            w_found;
    logic [IDXW-1:0] w_winner;
    logic            w_timeout;
    logic [NMST-1:0] w_unused_penable;

    // (base + off) mod NMST; base < NMST and off <= NMST, so one wrap suffices.
    function automatic logic [IDXW-1:0] rr_idx(input logic [IDXW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NMST) begin
            sum = sum - NMST;
        end
        return IDXW'(sum);
    endfunction

    // Round-robin pick: first requester after the previous owner, wrapping.
    // Offset NMST lands on the previous owner itself, so it only wins alone.
    always_comb begin
        w_found  = 1'b0;
        w_winner = last_q;
        for (int i = 1; i <= NMST; i++) begin
            if (!w_found && i_mst_apbi[rr_idx(last_q, i)].pselx) begin
                w_found  = 1'b1;
                w_winner = rr_idx(last_q, i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        wdog_d     = wdog_q;
        grant_d    = grant_q;
        slv_d      = slv_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        w_timeout  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    // Downstream fields are latched once and held until RESP,
                    // so a master dropping pselx early cannot disturb them.
                    slv_d         = apb_in_none;
                    slv_d.paddr   = i_mst_apbi[w_winner].paddr;
                    slv_d.pwrite  = i_mst_apbi[w_winner].pwrite;
                    slv_d.pwdata  = i_mst_apbi[w_winner].pwdata;
                    slv_d.pstrb   = i_mst_apbi[w_winner].pstrb;
                    slv_d.pprot   = i_mst_apbi[w_winner].pprot;
                    slv_d.pselx   = 1'b1;
                    slv_d.penable = 1'b0;
                    last_d        = w_winner;
                    grant_d       = GRANT_ONE << w_winner;
                    wdog_d        = '0;
                    state_d       = S_SETUP;
                end
            end
            S_SETUP: begin
                slv_d.penable = 1'b1;
                state_d       = S_ACCESS;
            end
            S_ACCESS: begin
                wdog_d = wdog_q + 1'b1;
                if (i_slv_apbo.pready) begin
                    rsp_data_d = i_slv_apbo.prdata;
                    rsp_err_d  = i_slv_apbo.pslverr;
                    slv_d      = apb_in_none;
                    state_d    = S_RESP;
                end else if ((TIMEOUT != 0) && (wdog_q == WDOG_LAST)) begin
                    rsp_data_d = 32'hFFFF_FFFF;
                    rsp_err_d  = 1'b1;
                    w_timeout  = 1'b1;
                    slv_d      = apb_in_none;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= S_IDLE;
            last_q     <= LAST_RST;
            wdog_q     <= '0;
            grant_q    <= '0;
            slv_q      <= apb_in_none;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            wdog_q     <= wdog_d;
            grant_q    <= grant_d;
            slv_q      <= slv_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Only the owner sees the response, and only during RESP.
    for (genvar g = 0; g < NMST; g++) begin : g_mst_rsp
        assign o_mst_apbo[g] = ((state_q == S_RESP) && grant_q[g])
                             ? {1'b1, rsp_data_q, rsp_err_q}
                             : apb_out_none;
        // The arbiter works on pselx alone; upstream penable carries no information here.
        assign w_unused_penable[g] = i_mst_apbi[g].penable;
    end

    assign o_slv_apbi = slv_q;
    assign o_grant    = grant_q;
    assign o_timeout  = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_accel_apb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_accel_apb_arbiter
//  Purpose  : Self-checking bench for accel_apb_arbiter (NMST=3, TIMEOUT=4).
//             Masters push expected responses into a scoreboard; a monitor
//             on the falling edge checks arbitration order, downstream
//             phases, latency, watchdog pulse and upstream responses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_accel_apb_arbiter;
    import accel_apb_pkg::*;

    localparam int NMST    = 3;
    localparam int TIMEOUT = 4;

    logic            clk;
    logic            nrst;
    apb_in_type      mst_in  [NMST];
    apb_out_type     mst_out [NMST];
    apb_in_type      slv_in;
    apb_out_type     slv_rsp;
    logic [NMST-1:0] grant;
    logic            tmo;

    accel_apb_arbiter #(.NMST(NMST), .TIMEOUT(TIMEOUT)) u_dut (
        .i_clk      (clk),
        .i_nrst     (nrst),
        .i_mst_apbi (mst_in),
        .o_mst_apbo (mst_out),
        .o_slv_apbi (slv_in),
        .i_slv_apbo (slv_rsp),
        .o_grant    (grant),
        .o_timeout  (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          mid;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Slave behaviour keyed by address: [5:4] wait states, [3] slverr,
    // [7] never responds. Read data is a fixed scramble of the address.
    function automatic logic [31:0] resp_data(input logic [31:0] a);
        return a ^ 32'hC3A5_0F96;
    endfunction

    function automatic int rr_pick(input logic [NMST-1:0] req, input int last);
        for (int k = 1; k <= NMST; k++) begin
            if (req[(last + k) % NMST]) return (last + k) % NMST;
        end
        return -1;
    endfunction

    function automatic logic [NMST-1:0] oh(input int i);
        logic [NMST-1:0] r;
        r = '0;
        if (i >= 0 && i < NMST) r[i] = 1'b1;
        return r;
    endfunction

    // ---------------- downstream slave model ----------------
    int acnt;
    initial begin
        slv_rsp = '0;
        acnt    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (slv_in.pselx && slv_in.penable) begin
                acnt++;
                slv_rsp.pready  = !slv_in.paddr[7] && (acnt == int'(slv_in.paddr[5:4]) + 1);
                slv_rsp.prdata  = slv_rsp.pready ? resp_data(slv_in.paddr) : $urandom;
                slv_rsp.pslverr = slv_rsp.pready ? slv_in.paddr[3] : 1'($urandom);
            end else begin
                acnt           = 0;
                slv_rsp        = '0;
                slv_rsp.prdata = $urandom;
            end
        end
    end

    // ---------------- upstream master driver ----------------
    task automatic do_req(input int m, input logic [31:0] a, input logic wr,
                          input logic [31:0] d, input int gap);
        bit ok;
        repeat (gap) @(posedge clk);
        #1;
        mst_in[m].paddr   = a;
        mst_in[m].pwrite  = wr;
        mst_in[m].pwdata  = d;
        mst_in[m].pstrb   = 4'($urandom);
        mst_in[m].pprot   = 3'($urandom);
        mst_in[m].pselx   = 1'b1;
        mst_in[m].penable = 1'b0;
        if (a[7]) sb.push_back('{m, 32'hFFFF_FFFF, 1'b1});
        else      sb.push_back('{m, resp_data(a), a[3]});
        @(posedge clk);
        #1;
        mst_in[m].penable = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (mst_out[m].pready) ok = 1'b1;
        end
        if (!ok) fail_now($sformatf("pready_bound m%0d", m));
        @(posedge clk);
        #1;
        mst_in[m].pselx   = 1'b0;
        mst_in[m].penable = 1'b0;
    endtask

    task automatic run_master(input int m, input int n);
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            a    = $urandom;
            a[7] = ($urandom_range(0, 7) == 0);
            do_req(m, a, 1'($urandom), $urandom, (m == 1) ? 0 : int'($urandom_range(0, 4)));
        end
    endtask

    // ---------------- monitor ----------------
    int              cyc = 0;
    int              setup_cyc, lat, phase, owner, w, idx, resp_now, last_m;
    bit              active = 1'b0;
    bit              prev_valid = 1'b0;
    bit              hang, exp_tmo;
    logic [NMST-1:0] prev_req, prev_g, quiet;
    apb_in_type      snap;

    always @(negedge clk) begin
        quiet = '0;
        if (!nrst) begin
            for (int m = 0; m < NMST; m++) quiet[m] = (mst_out[m] != '0);
            chk("rst_outputs", {grant, tmo, quiet}, '0);
            chk("rst_slv", slv_in, '0);
            active     = 1'b0;
            last_m     = NMST - 1;
            prev_valid = 1'b0;
            prev_g     = '0;
        end else begin
            cyc++;
            resp_now = -1;
            exp_tmo  = 1'b0;
            if (active && (cyc - setup_cyc) == lat + 1) begin
                chk("grant_release", grant, '0);
                active = 1'b0;
            end else if (!active) begin
                if (grant != '0) begin
                    w = prev_valid ? rr_pick(prev_req, last_m) : -1;
                    chk("rr_winner", grant, oh(w));
                    owner = -1;
                    for (int m = 0; m < NMST; m++) if (grant == oh(m)) owner = m;
                    if (owner >= 0) begin
                        active    = 1'b1;
                        setup_cyc = cyc;
                        last_m    = owner;
                        snap      = mst_in[owner];
                        hang      = snap.paddr[7];
                        lat       = hang ? TIMEOUT + 1 : 2 + int'(snap.paddr[5:4]);
                    end
                end else if (prev_valid && prev_g == '0 && prev_req != '0) begin
                    chk("missed_grant", grant, oh(rr_pick(prev_req, last_m)));
                end
            end

            if (active) begin
                phase = cyc - setup_cyc;
                chk("grant_hold", grant, oh(owner));
                if (phase < lat) begin
                    chk("dn_ctrl", {slv_in.pselx, slv_in.penable}, {1'b1, phase != 0});
                    chk("dn_fields",
                        {slv_in.paddr, slv_in.pwrite, slv_in.pwdata, slv_in.pstrb, slv_in.pprot},
                        {snap.paddr, snap.pwrite, snap.pwdata, snap.pstrb, snap.pprot});
                    exp_tmo = hang && (phase == TIMEOUT);
                end else begin
                    resp_now = owner;
                    chk("dn_resp_none", slv_in, '0);
                    chk("rsp_pready", mst_out[owner].pready, 1'b1);
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].mid == owner) idx = i;
                    if (idx < 0) begin
                        fail_now($sformatf("sb_unexpected m%0d", owner));
                    end else begin
                        chk("rsp_prdata", mst_out[owner].prdata, sb[idx].data);
                        chk("rsp_pslverr", mst_out[owner].pslverr, sb[idx].err);
                        sb.delete(idx);
                    end
                end
            end else begin
                chk("dn_idle", {slv_in.pselx, slv_in.penable}, '0);
            end

            chk("timeout_pulse", tmo, exp_tmo);
            for (int m = 0; m < NMST; m++) quiet[m] = (m != resp_now) && (mst_out[m] != '0);
            chk("quiet_rsp", quiet, '0);

            for (int m = 0; m < NMST; m++) prev_req[m] = mst_in[m].pselx;
            prev_g     = grant;
            prev_valid = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [NMST-1:0] q2;
        nrst = 1'b0;
        for (int m = 0; m < NMST; m++) mst_in[m] = '0;
        repeat (3) @(posedge clk);
        #3 nrst = 1'b1;

        // simultaneous reads after reset: master 0 then master 1
        fork
            do_req(0, 32'h0000_0100, 1'b0, 32'h0, 1);
            do_req(1, 32'h0000_0200, 1'b0, 32'h0, 1);
        join
        // single zero-wait write from master 0
        do_req(0, 32'h0000_1000, 1'b1, 32'hA5A5_A5A5, 1);
        // simultaneous pair with last owner 0: master 1 then master 0
        fork
            do_req(0, 32'h0000_0110, 1'b0, 32'h0, 1);
            do_req(1, 32'h0000_0210, 1'b0, 32'h0, 1);
        join
        // three wait states with slave error
        do_req(2, 32'h0000_2038, 1'b1, 32'h1234_5678, 1);
        // hung slave, then a normal transfer straight after
        do_req(0, 32'h0000_3080, 1'b0, 32'h0, 1);
        do_req(0, 32'h0000_3000, 1'b0, 32'h0, 0);
        // master 1 streams back-to-back while master 0 asks once
        fork
            begin
                for (int k = 0; k < 5; k++) do_req(1, 32'h0000_5000 + 32'(k * 16), 1'b1, $urandom, 0);
            end
            do_req(0, 32'h0000_5400, 1'b0, 32'h0, 3);
        join
        // randomized contention
        fork
            run_master(0, 20);
            run_master(1, 20);
            run_master(2, 20);
        join

        // asynchronous reset in the middle of ACCESS
        @(posedge clk);
        #1;
        mst_in[0].paddr   = 32'h0000_4030;
        mst_in[0].pwrite  = 1'b1;
        mst_in[0].pwdata  = 32'hDEAD_BEEF;
        mst_in[0].pstrb   = 4'hF;
        mst_in[0].pprot   = 3'h0;
        mst_in[0].pselx   = 1'b1;
        mst_in[0].penable = 1'b0;
        @(posedge clk);
        #1 mst_in[0].penable = 1'b1;
        @(posedge clk);
        #3 nrst = 1'b0;
        #1;
        for (int m = 0; m < NMST; m++) q2[m] = mst_out[m].pready;
        chk("async_rst", {grant, slv_in.pselx, slv_in.penable, q2}, '0);
        mst_in[0] = '0;
        repeat (2) @(posedge clk);
        #3 nrst = 1'b1;
        do_req(1, 32'h0000_6004, 1'b0, 32'h0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        total++;
        bad++;
        $display("FAIL global_watchdog: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timed out");
    end

endmodule

`default_nettype wire
